// File: rtl/ysyx_24110015_ifu_if.sv
// AXI-lite style read channel (AR + R) between the fetch unit and instruction memory.
// The master side issues the address and accepts data; the slave side answers.
interface ysyx_24110015_ifu_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr,
        output arvalid,
        input  arready,
        input  rdata,
        input  rresp,
        input  rvalid,
        output rready
    );

    modport slave (
        input  araddr,
        input  arvalid,
        output arready,
        output rdata,
        output rresp,
        output rvalid,
        input  rready
    );
endinterface

// File: rtl/ysyx_24110015_ifu.sv
// Instruction fetch unit: holds the PC and performs one AR/R read per controller request,
// returning the instruction with a single-cycle completion pulse.
module ysyx_24110015_ifu #(
    parameter logic [31:0] PC_RESET = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      control_iMemRead,
    input  logic                      control_RegWrite,
    input  logic [31:0]               dnpc,
    output logic [31:0]               pc,
    output logic [31:0]               inst,
    output logic                      control_iMemRead_end,
    output logic                      fetch_err,
    ysyx_24110015_ifu_if.master       bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_AR   = 2'b01,
        S_R    = 2'b10
    } state_e;

    state_e      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] inst_q,    inst_d;
    logic [31:0] araddr_q,  araddr_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q,  rready_d;
    logic        end_q,     end_d;
    logic        err_q,     err_d;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return (addr[1:0] != 2'b00);
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp != 2'b00);
    endfunction

    // Next-state and next-output logic for the fetch FSM and the PC.
    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        araddr_d  = araddr_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        err_d     = err_q;
        end_d     = 1'b0;

        if (control_RegWrite) begin
            pc_d = dnpc;
        end else begin
            pc_d = pc_q;
        end

        case (state_q)
            S_IDLE: begin
                // A request coinciding with the end pulse is dropped, not queued.
                if (control_iMemRead && !end_q) begin
                    if (is_misaligned(pc_q)) begin
                        state_d = S_IDLE;
                        end_d   = 1'b1;
                        err_d   = 1'b1;
                        inst_d  = NOP_INST;
                    end else begin
                        state_d   = S_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = pc_q;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AR: begin
                if (arvalid_q && bus.arready) begin
                    state_d   = S_R;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else begin
                    state_d = S_AR;
                end
            end
            S_R: begin
                if (rready_q && bus.rvalid) begin
                    state_d  = S_IDLE;
                    rready_d = 1'b0;
                    end_d    = 1'b1;
                    if (resp_is_err(bus.rresp)) begin
                        err_d  = 1'b1;
                        inst_d = NOP_INST;
                    end else begin
                        err_d  = 1'b0;
                        inst_d = bus.rdata;
                    end
                end else begin
                    state_d = S_R;
                end
            end
            default: begin
                state_d   = S_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= PC_RESET;
            inst_q    <= NOP_INST;
            araddr_q  <= 32'h0000_0000;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            end_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            end_q     <= end_d;
            err_q     <= err_d;
        end
    end

    assign pc                   = pc_q;
    assign inst                 = inst_q;
    assign control_iMemRead_end = end_q;
    assign fetch_err            = err_q;
    assign bus.araddr           = araddr_q;
    assign bus.arvalid          = arvalid_q;
    assign bus.rready           = rready_q;

endmodule

// File: tb/tb_ysyx_24110015_ifu.sv
// Directed bench for the fetch unit: the memory side is driven by hand, one cycle at a time,
// and every observed output is compared against hand-computed values.
module tb_ysyx_24110015_ifu;

    logic        clk;
    logic        rst;
    logic        control_iMemRead;
    logic        control_RegWrite;
    logic [31:0] dnpc;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        control_iMemRead_end;
    logic        fetch_err;

    int total = 0;
    int bad   = 0;

    ysyx_24110015_ifu_if bus ();

    ysyx_24110015_ifu dut (
        .clk                  (clk),
        .rst                  (rst),
        .control_iMemRead     (control_iMemRead),
        .control_RegWrite     (control_RegWrite),
        .dnpc                 (dnpc),
        .pc                   (pc),
        .inst                 (inst),
        .control_iMemRead_end (control_iMemRead_end),
        .fetch_err            (fetch_err),
        .bus                  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_pc"},      pc,                          32'h8000_0000);
        chk({tag, "_inst"},    inst,                        32'h0000_0013);
        chk({tag, "_end"},     {31'd0, control_iMemRead_end}, 32'd0);
        chk({tag, "_err"},     {31'd0, fetch_err},          32'd0);
        chk({tag, "_arvalid"}, {31'd0, bus.arvalid},        32'd0);
        chk({tag, "_rready"},  {31'd0, bus.rready},         32'd0);
        chk({tag, "_araddr"},  bus.araddr,                  32'h0000_0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        rst              = 1'b0;
        control_iMemRead = 1'b0;
        control_RegWrite = 1'b0;
        dnpc             = 32'h0000_0000;
        bus.arready      = 1'b0;
        bus.rdata        = 32'h0000_0000;
        bus.rresp        = 2'b00;
        bus.rvalid       = 1'b0;
        tick();
        tick();
        chk_reset_state("reset");

        // 1: zero-wait fetch at the reset PC
        rst = 1'b1;
        tick();
        control_iMemRead = 1'b1;
        bus.arready      = 1'b1;
        bus.rdata        = 32'h0010_0093;
        tick();
        control_iMemRead = 1'b0;
        chk("t1_arvalid", {31'd0, bus.arvalid}, 32'd1);
        chk("t1_araddr",  bus.araddr,           32'h8000_0000);
        chk("t1_end_T1",  {31'd0, control_iMemRead_end}, 32'd0);
        tick();
        chk("t1_arvalid_low", {31'd0, bus.arvalid}, 32'd0);
        chk("t1_rready",      {31'd0, bus.rready},  32'd1);
        chk("t1_end_T2",      {31'd0, control_iMemRead_end}, 32'd0);
        bus.rvalid = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        chk("t1_end_T3", {31'd0, control_iMemRead_end}, 32'd1);
        chk("t1_inst",   inst,                          32'h0010_0093);
        chk("t1_err",    {31'd0, fetch_err},            32'd0);
        chk("t1_rready_low", {31'd0, bus.rready},       32'd0);
        tick();
        chk("t1_end_T4", {31'd0, control_iMemRead_end}, 32'd0);
        chk("t1_inst_held", inst, 32'h0010_0093);

        // 2: three arready wait cycles, two rvalid wait cycles -> end at T+8
        bus.arready      = 1'b0;
        bus.rdata        = 32'h0020_8113;
        control_iMemRead = 1'b1;
        tick();
        control_iMemRead = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            chk("t2_arvalid_hold", {31'd0, bus.arvalid}, 32'd1);
            chk("t2_araddr_hold",  bus.araddr,           32'h8000_0000);
            tick();
            if (control_iMemRead_end) pulses++;
        end
        chk("t2_arvalid_hold4", {31'd0, bus.arvalid}, 32'd1);
        bus.arready = 1'b1;
        tick();
        bus.arready = 1'b0;
        if (control_iMemRead_end) pulses++;
        for (int i = 0; i < 2; i++) begin
            chk("t2_rready_hold", {31'd0, bus.rready}, 32'd1);
            tick();
            if (control_iMemRead_end) pulses++;
        end
        chk("t2_rready_hold3", {31'd0, bus.rready}, 32'd1);
        chk("t2_no_early_end", pulses, 32'd0);
        bus.rvalid = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        chk("t2_end_T8", {31'd0, control_iMemRead_end}, 32'd1);
        chk("t2_inst",   inst, 32'h0020_8113);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (control_iMemRead_end) pulses++;
        end
        chk("t2_single_pulse", pulses, 32'd0);

        // 3: commit in IDLE, then fetch from the new PC
        control_RegWrite = 1'b1;
        dnpc             = 32'h8000_0004;
        tick();
        control_RegWrite = 1'b0;
        chk("t3_pc", pc, 32'h8000_0004);
        control_iMemRead = 1'b1;
        bus.arready      = 1'b1;
        bus.rdata        = 32'h0000_0513;
        tick();
        control_iMemRead = 1'b0;
        chk("t3_araddr", bus.araddr, 32'h8000_0004);
        tick();
        bus.rvalid = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        chk("t3_end",  {31'd0, control_iMemRead_end}, 32'd1);
        chk("t3_inst", inst, 32'h0000_0513);
        tick();

        // commit and request together: fetch uses the pre-update PC
        control_RegWrite = 1'b1;
        dnpc             = 32'h8000_0006;
        control_iMemRead = 1'b1;
        tick();
        control_RegWrite = 1'b0;
        control_iMemRead = 1'b0;
        chk("t3b_araddr_old", bus.araddr, 32'h8000_0004);
        chk("t3b_pc_new",     pc,         32'h8000_0006);
        tick();
        bus.rvalid = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        chk("t3b_end", {31'd0, control_iMemRead_end}, 32'd1);
        tick();

        // 4: misaligned PC, request held two cycles: one pulse, second request dropped
        control_iMemRead = 1'b1;
        tick();
        chk("t4_arvalid", {31'd0, bus.arvalid}, 32'd0);
        chk("t4_end_T1",  {31'd0, control_iMemRead_end}, 32'd1);
        chk("t4_err",     {31'd0, fetch_err}, 32'd1);
        chk("t4_inst",    inst, 32'h0000_0013);
        tick();
        control_iMemRead = 1'b0;
        chk("t4_end_T2",     {31'd0, control_iMemRead_end}, 32'd0);
        chk("t4_arvalid2",   {31'd0, bus.arvalid}, 32'd0);
        chk("t4_err_held",   {31'd0, fetch_err}, 32'd1);
        tick();
        chk("t4_end_T3", {31'd0, control_iMemRead_end}, 32'd0);

        // 5: error response, then a good fetch clears the error
        control_RegWrite = 1'b1;
        dnpc             = 32'h8000_0008;
        tick();
        control_RegWrite = 1'b0;
        control_iMemRead = 1'b1;
        bus.rdata        = 32'hDEAD_BEEF;
        bus.rresp        = 2'b10;
        tick();
        control_iMemRead = 1'b0;
        chk("t5_araddr", bus.araddr, 32'h8000_0008);
        tick();
        bus.rvalid = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        chk("t5_end",  {31'd0, control_iMemRead_end}, 32'd1);
        chk("t5_err",  {31'd0, fetch_err}, 32'd1);
        chk("t5_inst", inst, 32'h0000_0013);
        tick();
        control_iMemRead = 1'b1;
        bus.rdata        = 32'h0030_0193;
        bus.rresp        = 2'b00;
        tick();
        control_iMemRead = 1'b0;
        tick();
        bus.rvalid = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        chk("t5_good_end",  {31'd0, control_iMemRead_end}, 32'd1);
        chk("t5_good_err",  {31'd0, fetch_err}, 32'd0);
        chk("t5_good_inst", inst, 32'h0030_0193);
        tick();

        // 6a: reset while in R abandons the fetch
        control_iMemRead = 1'b1;
        tick();
        control_iMemRead = 1'b0;
        tick();
        chk("t6a_in_R", {31'd0, bus.rready}, 32'd1);
        rst        = 1'b0;
        bus.rvalid = 1'b1;
        tick();
        chk_reset_state("t6a");
        rst        = 1'b1;
        bus.rvalid = 1'b0;
        tick();
        chk("t6a_no_end", {31'd0, control_iMemRead_end}, 32'd0);

        // 6b: second request in AR is ignored; commit there leaves araddr alone
        bus.arready      = 1'b0;
        control_iMemRead = 1'b1;
        tick();
        chk("t6b_araddr", bus.araddr, 32'h8000_0000);
        control_RegWrite = 1'b1;
        dnpc             = 32'h8000_0010;
        tick();
        control_iMemRead = 1'b0;
        control_RegWrite = 1'b0;
        chk("t6b_araddr_stable", bus.araddr, 32'h8000_0000);
        chk("t6b_pc",            pc,         32'h8000_0010);
        bus.arready = 1'b1;
        bus.rdata   = 32'h0040_0213;
        tick();
        bus.rvalid = 1'b1;
        tick();
        bus.rvalid = 1'b0;
        chk("t6b_end",  {31'd0, control_iMemRead_end}, 32'd1);
        chk("t6b_inst", inst, 32'h0040_0213);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (control_iMemRead_end || bus.arvalid) pulses++;
        end
        chk("t6b_not_queued", pulses, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
